// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Instruction-phase sequencer for a 16-bit two-operand CPU. It walks each
// fetched instruction through its memory phases (source index/read,
// destination index/read, execute, write-back, stack push/pop). It also
// handles interrupt entry and an optional repeat-prefix extension word.
//
// Parameters
//   RPT_BITS  width of the repeat counter
//   EXT_EN    1: repeat prefixes are honoured; 0: a prefix decodes as a NOP
//
// Ports
//   clk        sole clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   IR         instruction word, sampled in FETCH when ir_valid=1
//   ir_valid   a fetched word is present
//   mem_ready  the memory access of the current phase completes this cycle
//   int_req    maskable interrupt request (qualified by gie)
//   gie        global interrupt enable
//   nmi_req    non-maskable interrupt request
//   state      current sequencer state code
//   fetch .. pop  phase strobes, high while in the matching state
//   INTACK     high in the INT_VEC cycle that completes the vector load
//   rpt_cnt    remaining repeat iterations
//   busy       high in every state except FETCH
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int RPT_BITS = 4,
  parameter int EXT_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         IR,
  input  logic                ir_valid,
  input  logic                mem_ready,
  input  logic                int_req,
  input  logic                gie,
  input  logic                nmi_req,
  output logic [3:0]          state,
  output logic                fetch,
  output logic                idx_fetch,
  output logic                src_rd,
  output logic                dst_rd,
  output logic                exec,
  output logic                wb,
  output logic                push,
  output logic                pop,
  output logic                INTACK,
  output logic [RPT_BITS-1:0] rpt_cnt,
  output logic                busy
);

  typedef enum logic [3:0] {
    S_RSTV    = 4'd0,
    S_FETCH   = 4'd1,
    S_SRC_IDX = 4'd2,
    S_SRC_RD  = 4'd3,
    S_DST_IDX = 4'd4,
    S_DST_RD  = 4'd5,
    S_EXEC    = 4'd6,
    S_WB      = 4'd7,
    S_PUSH    = 4'd8,
    S_POP_SR  = 4'd9,
    S_POP_PC  = 4'd10,
    S_INT_PC  = 4'd11,
    S_INT_SR  = 4'd12,
    S_INT_VEC = 4'd13
  } state_t;

  // Phases an instruction needs, resolved once while it is in FETCH.
  typedef struct packed {
    logic sidx;   // source index word fetch
    logic srd;    // source operand read
    logic didx;   // destination index word fetch
    logic drd;    // destination operand read
    logic wb;     // result write-back after EXEC
    logic push;   // stack push after EXEC (PUSH / CALL)
    logic reti;   // return from interrupt: POP_SR, POP_PC
    logic pfx;    // repeat prefix word
    logic rr;     // format I register-to-register (repeatable)
  } dec_t;

  state_t        st;
  state_t        nxt;
  dec_t          dec;
  logic          int_take;
  logic          accept;
  logic          rpt_pend;

  // Per-instruction phase flags latched on decode.
  logic          srd_q;
  logic          didx_q;
  logic          drd_q;
  logic          wb_q;
  logic          push_q;
  logic          rep_q;

  // The byte/word bit never changes the phase sequence.
  logic          unused_bw;
  assign unused_bw = IR[6];

  // Source operand phases for register r in addressing mode as.
  // Returns {index fetch, operand read}.
  function automatic logic [1:0] src_path(input logic [3:0] r,
                                          input logic [1:0] as);
    logic cg;
    // R3 in any mode and R2 in modes 10/11 are constant generators: no memory.
    cg = (r == 4'd3) || ((r == 4'd2) && as[1]);
    if (cg || (as == 2'b00)) return 2'b00;
    if (as == 2'b01)         return 2'b11;
    // @PC+ is the immediate form: the index word is the operand itself.
    if ((as == 2'b11) && (r == 4'd0)) return 2'b10;
    return 2'b01;
  endfunction

  function automatic dec_t decode(input logic [15:0] ir);
    dec_t       d;
    logic [1:0] sp;
    d  = '0;
    sp = 2'b00;
    if (ir[15:12] >= 4'd4) begin
      // Format I: two operands.
      sp     = src_path(ir[11:8], ir[5:4]);
      d.sidx = sp[1];
      d.srd  = sp[0];
      d.didx = ir[7];
      d.drd  = ir[7] && (ir[15:12] != 4'h4);        // MOV does not read dst
      d.wb   = ir[7] && (ir[15:12] != 4'h9) && (ir[15:12] != 4'hB);
      d.rr   = (ir[5:4] == 2'b00) && !ir[7];
    end else if (ir[15:10] == 6'b000100) begin
      // Format II: single operand.
      sp = src_path(ir[3:0], ir[5:4]);
      case (ir[9:7])
        3'd0, 3'd1, 3'd2, 3'd3: begin               // RRC SWPB RRA SXT
          d.sidx = sp[1];
          d.srd  = sp[0];
          d.wb   = (ir[5:4] != 2'b00);
        end
        3'd4, 3'd5: begin                           // PUSH CALL
          d.sidx = sp[1];
          d.srd  = sp[0];
          d.push = 1'b1;
        end
        3'd6:    d.reti = 1'b1;
        default: ;                                  // unused opcode: EXEC only
      endcase
    end else if ((EXT_EN != 0) && (ir[15:11] == 5'b00011)) begin
      d.pfx = 1'b1;
    end
    // Jumps and anything illegal fall through to a plain EXEC.
    return d;
  endfunction

  assign dec      = decode(IR);
  // A pending repeat must reach its follower before any interrupt.
  assign int_take = !rpt_pend && (nmi_req || (int_req && gie));
  assign accept   = (st == S_FETCH) && !int_take && ir_valid;

  always_comb begin
    nxt = st;
    case (st)
      S_RSTV:    if (mem_ready) nxt = S_FETCH;
      S_FETCH: begin
        if (int_take)                nxt = S_INT_PC;
        else if (ir_valid) begin
          if (dec.pfx)               nxt = S_FETCH;
          else if (dec.reti)         nxt = S_POP_SR;
          else if (dec.sidx)         nxt = S_SRC_IDX;
          else if (dec.srd)          nxt = S_SRC_RD;
          else if (dec.didx)         nxt = S_DST_IDX;
          else                       nxt = S_EXEC;
        end
      end
      S_SRC_IDX: if (mem_ready) nxt = srd_q ? S_SRC_RD : (didx_q ? S_DST_IDX : S_EXEC);
      S_SRC_RD:  if (mem_ready) nxt = didx_q ? S_DST_IDX : S_EXEC;
      S_DST_IDX: if (mem_ready) nxt = drd_q ? S_DST_RD : S_EXEC;
      S_DST_RD:  if (mem_ready) nxt = S_EXEC;
      S_EXEC: begin
        // EXEC never waits on memory; it only repeats for a prefixed follower.
        if (rep_q && (rpt_cnt != '0)) nxt = S_EXEC;
        else if (wb_q)                nxt = S_WB;
        else if (push_q)              nxt = S_PUSH;
        else                          nxt = S_FETCH;
      end
      S_WB:      if (mem_ready) nxt = S_FETCH;
      S_PUSH:    if (mem_ready) nxt = S_FETCH;
      S_POP_SR:  if (mem_ready) nxt = S_POP_PC;
      S_POP_PC:  if (mem_ready) nxt = S_FETCH;
      S_INT_PC:  if (mem_ready) nxt = S_INT_SR;
      S_INT_SR:  if (mem_ready) nxt = S_INT_VEC;
      S_INT_VEC: if (mem_ready) nxt = S_FETCH;
      default:   nxt = S_RSTV;
    endcase
  end

  // Control state: sequencer state, registered strobes, repeat bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_RSTV;
      fetch     <= 1'b0;
      idx_fetch <= 1'b0;
      src_rd    <= 1'b0;
      dst_rd    <= 1'b0;
      exec      <= 1'b0;
      wb        <= 1'b0;
      push      <= 1'b0;
      pop       <= 1'b0;
      busy      <= 1'b1;
      rpt_cnt   <= '0;
      rpt_pend  <= 1'b0;
    end else begin
      st        <= nxt;
      // Strobes are registered from the next state so they track st exactly.
      fetch     <= (nxt == S_FETCH);
      idx_fetch <= (nxt == S_SRC_IDX) || (nxt == S_DST_IDX);
      src_rd    <= (nxt == S_SRC_RD);
      dst_rd    <= (nxt == S_DST_RD);
      exec      <= (nxt == S_EXEC);
      wb        <= (nxt == S_WB);
      push      <= (nxt == S_PUSH);
      pop       <= (nxt == S_POP_SR) || (nxt == S_POP_PC);
      busy      <= (nxt != S_FETCH);

      if (accept && dec.pfx) begin
        // Register form (IR[7]=1) carries no count: the follower runs once.
        rpt_cnt  <= IR[7] ? '0 : RPT_BITS'(IR[3:0]);
        rpt_pend <= 1'b1;
      end else if ((st == S_EXEC) && rep_q && (rpt_cnt != '0)) begin
        rpt_cnt  <= rpt_cnt - RPT_BITS'(1);
      end

      // The only return to FETCH while a repeat is pending is the follower
      // finishing, because interrupts are held off until then.
      if ((st != S_FETCH) && (nxt == S_FETCH)) rpt_pend <= 1'b0;
    end
  end

  // Phase flags are only consumed after a decode has loaded them.
  always_ff @(posedge clk) begin
    if (accept && !dec.pfx) begin
      srd_q  <= dec.srd;
      didx_q <= dec.didx;
      drd_q  <= dec.drd;
      wb_q   <= dec.wb;
      push_q <= dec.push;
      rep_q  <= rpt_pend && dec.rr;
    end
  end

  assign state  = st;
  assign INTACK = (st == S_INT_VEC) && mem_ready;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int S_RSTV = 0, S_FETCH = 1, S_SIDX = 2, S_SRD = 3, S_DIDX = 4,
                 S_DRD = 5, S_EXEC = 6, S_WB = 7, S_PUSH = 8, S_POPSR = 9,
                 S_POPPC = 10, S_INTPC = 11, S_INTSR = 12, S_INTVEC = 13;
  localparam int NV = 20;
  localparam int NRAND = 3000;

  logic        clk;
  logic        rst;
  logic [15:0] IR;
  logic        ir_valid, mem_ready, int_req, gie, nmi_req;
  logic [3:0]  state;
  logic        fetch, idx_fetch, src_rd, dst_rd, exec, wb, push, pop;
  logic        INTACK, busy;
  logic [3:0]  rpt_cnt;
  logic [17:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.RPT_BITS(4), .EXT_EN(1)) dut (
    .clk(clk), .rst(rst), .IR(IR), .ir_valid(ir_valid), .mem_ready(mem_ready),
    .int_req(int_req), .gie(gie), .nmi_req(nmi_req), .state(state),
    .fetch(fetch), .idx_fetch(idx_fetch), .src_rd(src_rd), .dst_rd(dst_rd),
    .exec(exec), .wb(wb), .push(push), .pop(pop), .INTACK(INTACK),
    .rpt_cnt(rpt_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {state, fetch, idx_fetch, src_rd, dst_rd, exec, wb, push, pop,
                INTACK, busy, rpt_cnt};

  // Observable outputs implied by a state code, current mem_ready and count.
  function automatic logic [17:0] exp_vec(input int s, input logic mr, input int c);
    logic [3:0] s4, c4;
    s4 = 4'(s);
    c4 = 4'(c);
    return {s4, s == S_FETCH, (s == S_SIDX) || (s == S_DIDX), s == S_SRD,
            s == S_DRD, s == S_EXEC, s == S_WB, s == S_PUSH,
            (s == S_POPSR) || (s == S_POPPC), (s == S_INTVEC) && mr,
            s != S_FETCH, c4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [17:0] e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (state %0d vs %0d)", nm, act, e,
               act[17:14], e[17:14]);
    end
  endtask

  task automatic expect_st(input string nm, input int s, input int c);
    check(nm, exp_vec(s, mem_ready, c));
  endtask

  // ---------------- behavioural reference model ----------------
  int m_st, m_cnt;
  bit m_pend, m_rep;
  int plan[$];

  task automatic plan_src(input logic [3:0] r, input logic [1:0] as);
    if (r == 3 || (r == 2 && as >= 2) || as == 0) begin
    end else if (as == 1) begin
      plan.push_back(S_SIDX);
      plan.push_back(S_SRD);
    end else if (as == 3 && r == 0) begin
      plan.push_back(S_SIDX);
    end else begin
      plan.push_back(S_SRD);
    end
  endtask

  task automatic build_plan(input logic [15:0] ir);
    int op;
    plan.delete();
    op = int'(ir[15:12]);
    if (op >= 4) begin
      plan_src(ir[11:8], ir[5:4]);
      if (ir[7]) begin
        plan.push_back(S_DIDX);
        if (op != 4) plan.push_back(S_DRD);
      end
      if (m_rep) repeat (m_cnt + 1) plan.push_back(S_EXEC);
      else plan.push_back(S_EXEC);
      if (ir[7] && op != 9 && op != 11) plan.push_back(S_WB);
    end else if (ir[15:10] == 6'b000100) begin
      case (int'(ir[9:7]))
        0, 1, 2, 3: begin
          plan_src(ir[3:0], ir[5:4]);
          plan.push_back(S_EXEC);
          if (ir[5:4] != 0) plan.push_back(S_WB);
        end
        4, 5: begin
          plan_src(ir[3:0], ir[5:4]);
          plan.push_back(S_EXEC);
          plan.push_back(S_PUSH);
        end
        6: begin
          plan.push_back(S_POPSR);
          plan.push_back(S_POPPC);
        end
        default: plan.push_back(S_EXEC);
      endcase
    end else begin
      plan.push_back(S_EXEC);
    end
  endtask

  task automatic model_step(input bit r, input bit mr, input bit iv,
                            input logic [15:0] ir, input bit irq, input bit g,
                            input bit nmi);
    int nx;
    if (r) begin
      m_st = S_RSTV; m_cnt = 0; m_pend = 0;
      plan.delete();
      return;
    end
    if (m_st == S_FETCH) begin
      if (!m_pend && (nmi || (irq && g))) begin
        plan.delete();
        plan.push_back(S_INTSR);
        plan.push_back(S_INTVEC);
        m_st = S_INTPC;
      end else if (iv) begin
        if (ir[15:11] == 5'b00011) begin
          m_cnt  = ir[7] ? 0 : int'(ir[3:0]);
          m_pend = 1;
        end else begin
          m_rep = m_pend && (ir[15:12] >= 4) && (ir[5:4] == 0) && !ir[7];
          build_plan(ir);
          m_st = plan.pop_front();
        end
      end
    end else if (m_st == S_EXEC || mr) begin
      if (m_st == S_EXEC && m_rep && m_cnt > 0) m_cnt--;
      nx = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
      if (nx == S_FETCH) m_pend = 0;
      m_st = nx;
    end
  endtask

  typedef struct packed {
    logic [15:0] ir;
    logic [3:0]  n;
    logic [31:0] seq;   // state codes, first in the low nibble
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [15:0] rir;
    bit rr, rmr, riv, rirq, rg, rnmi;

    vecs[0]  = '{16'h4594, 4'd6, 32'h0017_6432};  // MOV 2(R5),4(R4)
    vecs[1]  = '{16'h9405, 4'd2, 32'h0000_0016};  // CMP R4,R5
    vecs[2]  = '{16'h5405, 4'd2, 32'h0000_0016};  // ADD R4,R5
    vecs[3]  = '{16'h4035, 4'd3, 32'h0000_0162};  // MOV #imm,R5
    vecs[4]  = '{16'h4325, 4'd2, 32'h0000_0016};  // constant gen R3
    vecs[5]  = '{16'h4225, 4'd2, 32'h0000_0016};  // constant gen R2 As=10
    vecs[6]  = '{16'h4215, 4'd4, 32'h0000_1632};  // absolute &addr
    vecs[7]  = '{16'h4425, 4'd3, 32'h0000_0163};  // @R4
    vecs[8]  = '{16'h9485, 4'd4, 32'h0000_1654};  // CMP R4,x(R5)
    vecs[9]  = '{16'h5485, 4'd5, 32'h0001_7654};  // ADD R4,x(R5)
    vecs[10] = '{16'h1005, 4'd2, 32'h0000_0016};  // RRC R5
    vecs[11] = '{16'h1025, 4'd4, 32'h0000_1763};  // RRC @R5
    vecs[12] = '{16'h1205, 4'd3, 32'h0000_0186};  // PUSH R5
    vecs[13] = '{16'h1295, 4'd5, 32'h0001_8632};  // CALL x(R5)
    vecs[14] = '{16'h1300, 4'd3, 32'h0000_01A9};  // RETI
    vecs[15] = '{16'h2005, 4'd2, 32'h0000_0016};  // JNE
    vecs[16] = '{16'h1405, 4'd2, 32'h0000_0016};  // illegal
    vecs[17] = '{16'h0000, 4'd2, 32'h0000_0016};  // illegal
    vecs[18] = '{16'h4080, 4'd4, 32'h0000_1764};  // MOV R0,x(R0)
    vecs[19] = '{16'hB4A5, 4'd5, 32'h0001_6543};  // BIT @R4,x(R5)

    rst = 1'b1; IR = 16'h0; ir_valid = 1'b0; mem_ready = 1'b0;
    int_req = 1'b0; gie = 1'b0; nmi_req = 1'b0;

    // Reset, RSTV waits for the reset-vector load.
    tick(); tick();
    expect_st("reset_state", S_RSTV, 0);
    rst = 1'b0;
    tick();
    expect_st("rstv_hold", S_RSTV, 0);
    mem_ready = 1'b1;
    tick();
    expect_st("rstv_to_fetch", S_FETCH, 0);

    // Table of single instructions with memory always ready.
    for (int v = 0; v < NV; v++) begin
      IR = vecs[v].ir; ir_valid = 1'b1; mem_ready = 1'b1;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        tick();
        ir_valid = 1'b0;
        expect_st($sformatf("tbl_%h_step%0d", vecs[v].ir, k),
                  int'(vecs[v].seq[4*k +: 4]), 0);
      end
    end

    // CMP with memory never ready: EXEC does not wait.
    mem_ready = 1'b0; IR = 16'h9405; ir_valid = 1'b1;
    tick(); ir_valid = 1'b0;
    expect_st("cmp_nomem_exec", S_EXEC, 0);
    tick();
    expect_st("cmp_nomem_fetch", S_FETCH, 0);

    // Maskable interrupt with INT_SR stalled two cycles.
    mem_ready = 1'b1; int_req = 1'b1; gie = 1'b1;
    tick(); int_req = 1'b0;
    expect_st("int_pc", S_INTPC, 0);
    tick();
    expect_st("int_sr1", S_INTSR, 0);
    mem_ready = 1'b0;
    tick();
    expect_st("int_sr2", S_INTSR, 0);
    tick();
    expect_st("int_sr3", S_INTSR, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; #1;
    expect_st("int_vec_wait", S_INTVEC, 0);
    mem_ready = 1'b1; #1;
    expect_st("int_vec_ack", S_INTVEC, 0);
    tick();
    expect_st("int_done", S_FETCH, 0);

    // Repeat prefix, interrupt held off until the follower completes.
    IR = 16'h1843; ir_valid = 1'b1;
    tick();
    expect_st("pfx_load", S_FETCH, 3);
    IR = 16'h5405; int_req = 1'b1; gie = 1'b1;
    tick(); ir_valid = 1'b0;
    expect_st("rpt_exec3", S_EXEC, 3);
    tick(); expect_st("rpt_exec2", S_EXEC, 2);
    tick(); expect_st("rpt_exec1", S_EXEC, 1);
    tick(); expect_st("rpt_exec0", S_EXEC, 0);
    tick(); expect_st("rpt_done", S_FETCH, 0);
    tick(); expect_st("int_after_rpt", S_INTPC, 0);
    int_req = 1'b0;
    tick(); tick(); tick();
    expect_st("int_after_rpt_done", S_FETCH, 0);

    // Back-to-back prefixes: the later count wins.
    IR = 16'h1845; ir_valid = 1'b1;
    tick(); expect_st("pfx_a", S_FETCH, 5);
    IR = 16'h1842;
    tick(); expect_st("pfx_b", S_FETCH, 2);
    IR = 16'h5405;
    tick(); ir_valid = 1'b0;
    expect_st("b2b_exec2", S_EXEC, 2);
    tick(); expect_st("b2b_exec1", S_EXEC, 1);
    tick(); expect_st("b2b_exec0", S_EXEC, 0);
    tick(); expect_st("b2b_done", S_FETCH, 0);

    // Register-form prefix: no repeat.
    IR = 16'h1885; ir_valid = 1'b1;
    tick(); expect_st("pfx_reg", S_FETCH, 0);
    IR = 16'h5405;
    tick(); ir_valid = 1'b0;
    expect_st("pfx_reg_exec", S_EXEC, 0);
    tick(); expect_st("pfx_reg_done", S_FETCH, 0);

    // NMI ignores gie and beats a valid word.
    nmi_req = 1'b1; gie = 1'b0; IR = 16'h5405; ir_valid = 1'b1;
    tick(); nmi_req = 1'b0; ir_valid = 1'b0;
    expect_st("nmi_taken", S_INTPC, 0);
    tick(); tick(); tick();
    expect_st("nmi_done", S_FETCH, 0);

    // Reset during POP_SR of RETI.
    mem_ready = 1'b0; IR = 16'h1300; ir_valid = 1'b1;
    tick(); ir_valid = 1'b0;
    expect_st("reti_popsr", S_POPSR, 0);
    rst = 1'b1;
    tick(); expect_st("reti_rst", S_RSTV, 0);
    rst = 1'b0; mem_ready = 1'b1;
    tick(); expect_st("reti_rst_fetch", S_FETCH, 0);

    // Reset mid-repeat clears the count and the pending repeat.
    IR = 16'h184F; ir_valid = 1'b1;
    tick(); expect_st("pfx_15", S_FETCH, 15);
    IR = 16'h5405;
    tick(); ir_valid = 1'b0;
    tick(); expect_st("rpt_mid", S_EXEC, 14);
    rst = 1'b1;
    tick(); expect_st("rpt_rst", S_RSTV, 0);
    rst = 1'b0;
    tick(); expect_st("rpt_rst_fetch", S_FETCH, 0);
    ir_valid = 1'b1;
    tick(); ir_valid = 1'b0;
    expect_st("post_rst_exec", S_EXEC, 0);
    tick(); expect_st("post_rst_once", S_FETCH, 0);

    // Randomized run against the reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    m_st = S_RSTV; m_cnt = 0; m_pend = 0; m_rep = 0; plan.delete();
    for (int i = 0; i < NRAND; i++) begin
      case ($urandom_range(0, 7))
        0: rir = {5'b00011, 11'($urandom)};
        1: rir = {6'b000100, 10'($urandom)};
        2: rir = {3'b001, 13'($urandom)};
        3: begin
          rir = 16'($urandom);
          rir[15:12] = 4'($urandom_range(4, 15));
          rir[7] = 1'b0; rir[5:4] = 2'b00;
        end
        default: rir = 16'($urandom);
      endcase
      rr   = ($urandom_range(0, 199) == 0);
      rmr  = ($urandom_range(0, 3) != 0);
      riv  = ($urandom_range(0, 2) != 0);
      rirq = ($urandom_range(0, 9) == 0);
      rg   = ($urandom_range(0, 1) == 1);
      rnmi = ($urandom_range(0, 29) == 0);
      rst = rr; mem_ready = rmr; ir_valid = riv; IR = rir;
      int_req = rirq; gie = rg; nmi_req = rnmi;
      #1;
      check($sformatf("rand_%0d", i), exp_vec(m_st, rmr, m_cnt));
      model_step(rr, rmr, riv, rir, rirq, rg, rnmi);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter RPT_BITS, default 4: width of the repeat counter.
REQ-002 Parameter EXT_EN, default 1: 1 enables extension-word (repeat prefix) handling; 0 decodes prefixes as illegal (treated as NOP, EXEC only).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 IR  in  16  instruction word, valid when ir_valid=1 in FETCH.
REQ-006 ir_valid  in  1  fetched word present.
REQ-007 mem_ready  in  1  current memory access completes this cycle.
REQ-008 int_req  in  1  maskable interrupt pending; gie  in  1  global interrupt enable; nmi_req  in  1  non-maskable request.
REQ-009 state  out  4  current sequencer state code (see REQ-013).
REQ-010 fetch, idx_fetch, src_rd, dst_rd, exec, wb, push, pop  out  1 each  phase strobes, high while in the matching state.
REQ-011 INTACK  out  1  one-cycle pulse on interrupt vector load completion.
REQ-012 rpt_cnt  out  RPT_BITS  remaining repeat iterations; busy  out  1  high in every state except FETCH.

Function
REQ-013 State codes: RSTV=0, FETCH=1, SRC_IDX=2, SRC_RD=3, DST_IDX=4, DST_RD=5, EXEC=6, WB=7, PUSH=8, POP_SR=9, POP_PC=10, INT_PC=11, INT_SR=12, INT_VEC=13.
REQ-014 Memory states (RSTV, SRC_IDX, SRC_RD, DST_IDX, DST_RD, WB, PUSH, POP_SR, POP_PC, INT_PC, INT_SR, INT_VEC) hold until mem_ready=1, then advance next cycle; FETCH holds until ir_valid=1; EXEC is always one cycle.
REQ-015 FETCH priority: nmi_req, then int_req&gie -> INT_PC; else ir_valid -> decode IR; interrupts are not taken while a repeat is pending.
REQ-016 Format I (IR[15:12]>=4): source path by As=IR[5:4], srcA=IR[11:8]: constant generator (srcA=3, or srcA=2 with As>=2) or As=00 -> no source states; As=01 -> SRC_IDX, SRC_RD; As=10/11 with srcA=0 and As=11 (immediate) -> SRC_IDX only; other As=10/11 -> SRC_RD.
REQ-017 Format I destination: Ad=IR[7]=1 -> DST_IDX, then DST_RD unless opcode MOV (4); then EXEC; then WB unless opcode CMP (9) or BIT (B); Ad=0 -> EXEC, no WB.
REQ-018 Format II (IR[15:10]=000100): operand path per REQ-016 with register IR[3:0]; RRC/SWPB/RRA/SXT with As!=00 end with WB; PUSH and CALL end EXEC -> PUSH; RETI -> POP_SR -> POP_PC.
REQ-019 Jumps (IR[15:13]=001): EXEC only.
REQ-020 Last state of every instruction returns to FETCH.
REQ-021 Interrupt entry: INT_PC -> INT_SR -> INT_VEC -> FETCH; INTACK=1 exactly in the INT_VEC cycle where mem_ready=1.
REQ-022 Repeat prefix (EXT_EN=1, IR[15:11]=00011): consumes one FETCH, loads rpt_cnt=IR[3:0] when IR[7]=0 (register form: rpt_cnt=0, no repeat), sets rpt_pend, returns to FETCH.
REQ-023 Following Format I register-register instruction with rpt_cnt=N runs EXEC N+1 consecutive cycles, rpt_cnt decrementing each EXEC cycle, saturating at 0; non-register-mode follower ignores rpt_cnt; rpt_pend clears when the follower completes.
REQ-024 Back-to-back prefixes: the later prefix overwrites rpt_cnt.
REQ-025 All phase strobes are Moore outputs of state only.

Reset
REQ-026 rst=1 forces state=RSTV, all strobes 0, INTACK=0, rpt_cnt=0, rpt_pend=0, busy=1, next cycle, regardless of current state, including mid-repeat or mid-interrupt.
REQ-027 After rst falls, RSTV waits for mem_ready (reset-vector load) then enters FETCH.

Verification
REQ-028 Reset, mem_ready=1 -> RSTV one cycle, then FETCH, busy=0.
REQ-029 IR=0x4594 (MOV 2(R5),4(R4)), mem_ready=1 -> SRC_IDX, SRC_RD, DST_IDX, EXEC, WB, FETCH (no DST_RD).
REQ-030 IR=0x9405 (CMP R4,R5) with mem_ready=0 throughout -> single EXEC, no WB, FETCH.
REQ-031 int_req=1, gie=1 in FETCH, mem_ready low 2 cycles in INT_SR -> INT_PC, INT_SR x3, INT_VEC, INTACK single pulse, FETCH.
REQ-032 Prefix 0x1843 then 0x5405 (ADD R4,R5) -> exec high 4 consecutive cycles, rpt_cnt 3,2,1,0; int_req asserted mid-repeat taken only after return to FETCH.
REQ-033 rst asserted during POP_SR of 0x1300 (RETI) -> state=RSTV next cycle, all outputs at reset values.
